// File: rtl/ysyx_23060184_issue_pkg.sv
// Shared types and constants for the issue controller and its scoreboard.
package ysyx_23060184_issue_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned ISSUE_ST_LENGTH = 2;

  typedef enum logic [ISSUE_ST_LENGTH-1:0] {
    ISSUE_ST_RUN   = 2'd0,
    ISSUE_ST_DRAIN = 2'd1,
    ISSUE_ST_SYS   = 2'd2
  } issue_state_t;

endpackage

// File: rtl/ysyx_23060184_scoreboard.sv
// Per-register pending-write counters: two busy read ports, an rd saturation check,
// one increment port (issue) and one decrement port (retire). x0 is never tracked.
module ysyx_23060184_scoreboard
  import ysyx_23060184_issue_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned NREG         = 32,
  parameter int unsigned CNT_W        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rd_sat,
  input  logic                      inc_en,
  input  logic [REG_ADDR_WIDTH-1:0] inc_rd,
  input  logic                      dec_en,
  input  logic [REG_ADDR_WIDTH-1:0] dec_rd,
  output logic                      err
);

  logic [CNT_W-1:0] pend [NREG];
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;

  function automatic logic tracked(input logic [REG_ADDR_WIDTH-1:0] addr);
    return (addr != '0) && (int'(addr) < int'(NREG));
  endfunction

  always_comb begin
    rs1_busy = tracked(rs1) && (pend[rs1] != '0);
    rs2_busy = tracked(rs2) && (pend[rs2] != '0);
    rd_sat   = tracked(rd) && (pend[rd] == CNT_W'(MAX_INFLIGHT));
    err      = dec_en && tracked(dec_rd) && (pend[dec_rd] == '0);
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en && tracked(inc_rd)) inc_vec[inc_rd] = 1'b1;
    if (dec_en && tracked(dec_rd)) dec_vec[dec_rd] = 1'b1;
  end

  // Matching inc/dec on one register cancel; a decrement at zero holds at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          pend[i] <= pend[i] + CNT_W'(1);
        end else if (dec_vec[i] && !inc_vec[i] && (pend[i] != '0)) begin
          pend[i] <= pend[i] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_23060184_issue_ctrl.sv
// Issue controller between IFU and EXU: valid/ready handshake, RAW/WAW-saturation
// stalls via the scoreboard, and serialisation of system instructions.
module ysyx_23060184_issue_ctrl
  import ysyx_23060184_issue_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned NREG         = 32,
  parameter int unsigned CNT_W        = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [REG_ADDR_WIDTH-1:0]  rs1,
  input  logic [REG_ADDR_WIDTH-1:0]  rs2,
  input  logic [REG_ADDR_WIDTH-1:0]  rd,
  input  logic                       uses_rs1,
  input  logic                       uses_rs2,
  input  logic                       reg_write,
  input  logic                       is_system,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  input  logic                       wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_rd,
  input  logic                       wb_reg_write,
  output logic [ISSUE_ST_LENGTH-1:0] state,
  output logic [CNT_W-1:0]           inflight,
  output logic [31:0]                stall_cycles,
  output logic                       sb_err
);

  issue_state_t state_q, state_d;
  logic         rs1_busy, rs2_busy, rd_sat, dec_err;
  logic         haz, full, idle, issue_req, transfer, retire_err;

  ysyx_23060184_scoreboard #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .NREG        (NREG),
    .CNT_W       (CNT_W)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .rs1     (rs1),
    .rs2     (rs2),
    .rd      (rd),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy),
    .rd_sat  (rd_sat),
    .inc_en  (transfer && reg_write),
    .inc_rd  (rd),
    .dec_en  (wb_valid && wb_reg_write),
    .dec_rd  (wb_rd),
    .err     (dec_err)
  );

  always_comb begin
    haz  = (uses_rs1 && rs1_busy) || (uses_rs2 && rs2_busy) || (reg_write && rd_sat);
    full = (inflight == CNT_W'(MAX_INFLIGHT));
    idle = (inflight == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ISSUE_ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    issue_req = 1'b0;
    unique case (state_q)
      ISSUE_ST_RUN: begin
        if (if_valid && is_system) begin
          if (idle && !haz) begin
            issue_req = 1'b1;
            if (ex_ready) state_d = ISSUE_ST_SYS;
          end else begin
            state_d = ISSUE_ST_DRAIN;
          end
        end else begin
          issue_req = if_valid && !haz && !full;
        end
      end
      ISSUE_ST_DRAIN: begin
        issue_req = if_valid && idle;
        if (issue_req && ex_ready) state_d = ISSUE_ST_SYS;
        else if (!if_valid)        state_d = ISSUE_ST_RUN;
      end
      ISSUE_ST_SYS: begin
        if (wb_valid) state_d = ISSUE_ST_RUN;
      end
      default: state_d = ISSUE_ST_RUN;
    endcase
  end

  // Gated by rst so nothing is offered while the counters are being cleared.
  always_comb begin
    ex_valid   = issue_req && !rst;
    transfer   = ex_valid && ex_ready;
    if_ready   = transfer;
    retire_err = wb_valid && idle;
    state      = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight     <= '0;
      stall_cycles <= '0;
      sb_err       <= 1'b0;
    end else begin
      if (transfer && !wb_valid)                inflight <= inflight + CNT_W'(1);
      else if (wb_valid && !transfer && !idle)  inflight <= inflight - CNT_W'(1);
      if (if_valid && !transfer && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (retire_err || dec_err) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_issue_ctrl.sv
// Directed bench for the issue controller with hand-computed expectations.
module tb_ysyx_23060184_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [4:0]  rs1, rs2, rd;
  logic        uses_rs1, uses_rs2, reg_write, is_system;
  logic        ex_valid, ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [1:0]  state;
  logic [1:0]  inflight;
  logic [31:0] stall_cycles;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060184_issue_ctrl #(
    .MAX_INFLIGHT(3),
    .NREG        (32),
    .CNT_W       (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2),
    .reg_write   (reg_write),
    .is_system   (is_system),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_reg_write(wb_reg_write),
    .state       (state),
    .inflight    (inflight),
    .stall_cycles(stall_cycles),
    .sb_err      (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic present(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input logic u1, input logic u2,
                         input logic rw, input logic sys);
    if_valid  = v;
    rs1       = r1;
    rs2       = r2;
    rd        = d;
    uses_rs1  = u1;
    uses_rs2  = u2;
    reg_write = rw;
    is_system = sys;
  endtask

  task automatic retire(input logic v, input logic [4:0] d, input logic rw);
    wb_valid     = v;
    wb_rd        = d;
    wb_reg_write = rw;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    ex_ready = 1'b0;
    present(1, 0, 0, 0, 0, 0, 0, 0);
    retire(0, 0, 0);
    #2;
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_if_ready", 32'(if_ready), 0);
    repeat (2) cyc();
    check("rst_stall", stall_cycles, 0);
    present(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    settle();
    check("rst_inflight", 32'(inflight), 0);
    check("rst_state", 32'(state), 0);
    check("rst_sb_err", 32'(sb_err), 0);

    // RAW: addi x5 then add x6,x5,x5
    present(1, 0, 0, 5, 0, 0, 1, 0);
    settle();
    check("noready_ex_valid", 32'(ex_valid), 1);
    check("noready_if_ready", 32'(if_ready), 0);
    cyc();
    ex_ready = 1'b1;
    settle();
    check("addi_if_ready", 32'(if_ready), 1);
    check("stall_noready", stall_cycles, 1);
    cyc();
    check("addi_inflight", 32'(inflight), 1);
    present(1, 5, 5, 6, 1, 1, 1, 0);
    settle();
    check("raw_hold0", 32'(ex_valid), 0);
    cyc();
    settle();
    check("raw_hold1", 32'(ex_valid), 0);
    cyc();
    retire(1, 5, 1);
    settle();
    check("raw_no_bypass", 32'(ex_valid), 0);
    cyc();
    retire(0, 0, 0);
    settle();
    check("raw_release", 32'(ex_valid), 1);
    check("raw_inflight", 32'(inflight), 0);
    check("raw_stall", stall_cycles, 4);
    cyc();
    present(0, 0, 0, 0, 0, 0, 0, 0);
    retire(1, 6, 1);
    settle();
    check("add_inflight", 32'(inflight), 1);
    cyc();
    retire(0, 0, 0);
    settle();
    check("t2_drained", 32'(inflight), 0);

    // Full: three independent writes, fourth held
    present(1, 0, 0, 10, 0, 0, 1, 0);
    settle();
    check("ind0_ex_valid", 32'(ex_valid), 1);
    cyc();
    present(1, 0, 0, 11, 0, 0, 1, 0);
    cyc();
    present(1, 0, 0, 12, 0, 0, 1, 0);
    cyc();
    present(1, 0, 0, 13, 0, 0, 1, 0);
    settle();
    check("full_inflight", 32'(inflight), 3);
    check("full_hold", 32'(ex_valid), 0);
    retire(1, 10, 1);
    cyc();
    settle();
    check("full_after_retire", 32'(inflight), 2);
    check("fourth_issue", 32'(ex_valid), 1);
    retire(1, 11, 1);
    cyc();
    retire(0, 0, 0);
    settle();
    check("issue_retire_same", 32'(inflight), 2);
    present(1, 0, 0, 14, 0, 0, 1, 0);
    cyc();
    present(0, 0, 0, 0, 0, 0, 0, 0);
    retire(1, 12, 1);
    settle();
    check("refill_inflight", 32'(inflight), 3);
    cyc();
    retire(0, 0, 0);
    settle();
    check("t3_inflight", 32'(inflight), 2);
    check("t3_stall", stall_cycles, 5);

    // ecall with two in flight
    present(1, 0, 0, 0, 0, 0, 0, 1);
    settle();
    check("ecall_no_issue", 32'(ex_valid), 0);
    check("ecall_state_run", 32'(state), 0);
    cyc();
    settle();
    check("ecall_drain", 32'(state), 1);
    check("drain_hold", 32'(ex_valid), 0);
    retire(1, 13, 1);
    cyc();
    retire(1, 14, 1);
    settle();
    check("drain_inflight1", 32'(inflight), 1);
    check("drain_hold1", 32'(ex_valid), 0);
    cyc();
    retire(0, 0, 0);
    settle();
    check("drain_inflight0", 32'(inflight), 0);
    check("ecall_issue", 32'(ex_valid), 1);
    cyc();
    present(1, 2, 3, 1, 1, 1, 1, 0);
    settle();
    check("sys_state", 32'(state), 2);
    check("sys_inflight", 32'(inflight), 1);
    check("sys_hold", 32'(ex_valid), 0);
    cyc();
    retire(1, 0, 0);
    settle();
    check("sys_hold_wb", 32'(ex_valid), 0);
    cyc();
    retire(0, 0, 0);
    settle();
    check("sys_to_run", 32'(state), 0);
    check("sys_inflight0", 32'(inflight), 0);
    check("post_sys_issue", 32'(ex_valid), 1);
    check("t4_stall", stall_cycles, 10);
    cyc();
    present(0, 0, 0, 0, 0, 0, 0, 0);
    retire(1, 1, 1);
    cyc();
    retire(0, 0, 0);

    // WAW saturation on x7
    present(1, 0, 0, 7, 0, 0, 1, 0);
    repeat (3) cyc();
    present(0, 0, 0, 0, 0, 0, 0, 0);
    retire(1, 0, 0);
    settle();
    check("x7_inflight", 32'(inflight), 3);
    cyc();
    retire(0, 0, 0);
    present(1, 0, 0, 7, 0, 0, 1, 0);
    settle();
    check("x7_inflight2", 32'(inflight), 2);
    check("x7_sat_hold", 32'(ex_valid), 0);
    cyc();
    present(1, 0, 0, 8, 0, 0, 1, 0);
    settle();
    check("x8_issue", 32'(ex_valid), 1);
    check("t5_stall", stall_cycles, 11);
    cyc();
    present(0, 0, 0, 0, 0, 0, 0, 0);
    retire(1, 7, 1);
    settle();
    check("x8_inflight", 32'(inflight), 3);
    repeat (3) cyc();
    retire(0, 0, 0);
    settle();
    check("x7_drained", 32'(inflight), 0);
    check("no_err_yet", 32'(sb_err), 0);

    // x0 write is never tracked
    present(1, 0, 0, 0, 0, 0, 1, 0);
    settle();
    check("x0_issue", 32'(ex_valid), 1);
    cyc();
    present(0, 0, 0, 0, 0, 0, 0, 0);
    retire(1, 0, 1);
    cyc();
    retire(0, 0, 0);
    settle();
    check("x0_inflight", 32'(inflight), 0);
    check("x0_no_err", 32'(sb_err), 0);

    // Retire with nothing in flight
    retire(1, 8, 1);
    settle();
    check("err_registered", 32'(sb_err), 0);
    cyc();
    retire(0, 0, 0);
    settle();
    check("err_set", 32'(sb_err), 1);
    check("err_inflight", 32'(inflight), 0);
    ex_ready = 1'b0;
    present(1, 8, 7, 0, 1, 1, 0, 0);
    settle();
    check("pend_cleared", 32'(ex_valid), 1);
    repeat (2) cyc();
    check("err_sticky", 32'(sb_err), 1);

    // Reset mid-stream with two in flight
    ex_ready = 1'b1;
    present(1, 0, 0, 20, 0, 0, 1, 0);
    cyc();
    present(1, 0, 0, 21, 0, 0, 1, 0);
    cyc();
    present(1, 20, 0, 0, 1, 0, 0, 0);
    settle();
    check("pre_rst_inflight", 32'(inflight), 2);
    check("pre_rst_hold", 32'(ex_valid), 0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ex_valid", 32'(ex_valid), 0);
    check("mid_rst_if_ready", 32'(if_ready), 0);
    check("mid_rst_inflight", 32'(inflight), 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_sb_err", 32'(sb_err), 0);
    check("mid_rst_stall", stall_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
    settle();
    check("post_rst_pend_clear", 32'(ex_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
